// File: rtl/fpga_conf_rx_pkg.sv
// Shared constants for the ARM->FPGA configuration path: command codes, reset word,
// fpga_hf major-mode encodings and the receiver FSM state type.
package fpga_hf_pkg;

    localparam logic [3:0] CMD_SET_CONFREG = 4'b0001;
    localparam logic [7:0] CONF_RESET      = 8'hE0;

    localparam logic [2:0] MM_READ_TX       = 3'd0;
    localparam logic [2:0] MM_READ_RX_XCORR = 3'd1;
    localparam logic [2:0] MM_SIMULATE      = 3'd2;
    localparam logic [2:0] MM_ISO14443A     = 3'd3;
    localparam logic [2:0] MM_SNIFFER       = 3'd4;
    localparam logic [2:0] MM_OFF           = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2,
        ST_APPLY = 2'd3
    } conf_state_e;

    // Major mode lives in the top three bits of the configuration word.
    function automatic logic [2:0] major_of(input logic [7:0] conf);
        return conf[7:5];
    endfunction

endpackage

// File: rtl/fpga_conf_rx_if.sv
// SPI link between the ARM (master) and the FPGA configuration receiver (slave).
interface fpga_conf_rx_if;
    logic ncs;
    logic spck;
    logic mosi;
    logic miso;

    modport master (output ncs, output spck, output mosi, input miso);
    modport slave  (input ncs, input spck, input mosi, output miso);
endinterface

// File: rtl/fpga_conf_rx_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input with rise/fall detection on the
// synchronized value; RST_VAL sets the idle level so reset does not fake an edge.
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;

    // Synchronizer chain plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {STAGES{RST_VAL}};
            prev_r <= RST_VAL;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
            prev_r <= sync_r[STAGES-1];
        end
    end

    assign q    = sync_r[STAGES-1];
    assign rise = q & ~prev_r;
    assign fall = ~q & prev_r;

endmodule

// File: rtl/fpga_conf_rx.sv
// ARM->FPGA SPI configuration receiver, fully synchronous to pck0.
// Optional readback of the previous conf_word on miso: define FPGA_CONF_READBACK_EN.
module fpga_conf_rx
    import fpga_hf_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int WORD_BITS   = 16,
    parameter int CONF_BITS   = 8
) (
    input  logic                 pck0,
    input  logic                 nrst,
    fpga_conf_rx_if.slave        spi,
    output logic [CONF_BITS-1:0] conf_word,
    output logic [2:0]           major_mode,
    output logic                 conf_strobe,
    output logic                 frame_err
);

    logic ncs_q, ncs_rise, ncs_fall;
    logic spck_rise, spck_q_unused_s, spck_fall_unused_s;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic mosi_s;

    conf_state_e state_r, state_nx;
    logic [WORD_BITS-1:0] shift_reg_r;
    logic [4:0]           bitcnt_r;
    logic clear_s, shift_en_s, err_s, apply_s;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs_sync (
        .clk(pck0), .rst_n(nrst), .d(spi.ncs),
        .q(ncs_q), .rise(ncs_rise), .fall(ncs_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_spck_sync (
        .clk(pck0), .rst_n(nrst), .d(spi.spck),
        .q(spck_q_unused_s), .rise(spck_rise), .fall(spck_fall_unused_s)
    );

    // mosi uses the same depth as spck so data and clock edge stay aligned.
    always_ff @(posedge pck0 or negedge nrst) begin
        if (!nrst) begin
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi.mosi};
        end
    end

    assign mosi_s = mosi_sync_r[SYNC_STAGES-1];

    // FSM state register.
    always_ff @(posedge pck0 or negedge nrst) begin
        if (!nrst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ncs_fall) state_nx = ST_SHIFT;
                else          state_nx = ST_IDLE;
            end
            ST_SHIFT: begin
                if (ncs_rise) state_nx = ST_CHECK;
                else          state_nx = ST_SHIFT;
            end
            ST_CHECK: begin
                if ((bitcnt_r == 5'(WORD_BITS)) &&
                    (shift_reg_r[WORD_BITS-1 -: 4] == CMD_SET_CONFREG)) state_nx = ST_APPLY;
                else                                                      state_nx = ST_IDLE;
            end
            ST_APPLY: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // FSM control outputs; ncs_q low also excludes a spck edge coinciding with ncs_rise.
    always_comb begin
        clear_s    = 1'b0;
        shift_en_s = 1'b0;
        err_s      = 1'b0;
        apply_s    = 1'b0;
        case (state_r)
            ST_IDLE:  clear_s    = ncs_fall;
            ST_SHIFT: shift_en_s = spck_rise & ~ncs_q;
            ST_CHECK: err_s      = (bitcnt_r != 5'(WORD_BITS));
            ST_APPLY: apply_s    = 1'b1;
            default: begin
                clear_s = 1'b0;
            end
        endcase
    end

    // Frame shift register and saturating bit counter.
    always_ff @(posedge pck0 or negedge nrst) begin
        if (!nrst) begin
            shift_reg_r <= {WORD_BITS{1'b0}};
            bitcnt_r    <= 5'd0;
        end else if (clear_s) begin
            shift_reg_r <= {WORD_BITS{1'b0}};
            bitcnt_r    <= 5'd0;
        end else if (shift_en_s) begin
            shift_reg_r <= {shift_reg_r[WORD_BITS-2:0], mosi_s};
            bitcnt_r    <= (bitcnt_r == 5'd31) ? bitcnt_r : bitcnt_r + 5'd1;
        end
    end

    // Registered outputs; the configuration update is a single write, so fpga_hf never sees a partial word.
    always_ff @(posedge pck0 or negedge nrst) begin
        if (!nrst) begin
            conf_word   <= CONF_RESET[CONF_BITS-1:0];
            major_mode  <= major_of(CONF_RESET);
            conf_strobe <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            conf_strobe <= apply_s;
            frame_err   <= err_s;
            if (apply_s) begin
                conf_word  <= shift_reg_r[CONF_BITS-1:0];
                major_mode <= major_of(shift_reg_r[7:0]);
            end
        end
    end

`ifdef FPGA_CONF_READBACK_EN
    logic [WORD_BITS-1:0] shadow_r;
    logic                 shift_d_r;

    // Readback shadow: previous conf_word emerges on miso in frame bits 8..15.
    always_ff @(posedge pck0 or negedge nrst) begin
        if (!nrst) begin
            shadow_r  <= {WORD_BITS{1'b0}};
            shift_d_r <= 1'b0;
        end else begin
            shift_d_r <= shift_en_s;
            if (ncs_fall) begin
                shadow_r <= WORD_BITS'(conf_word);
            end else if (shift_d_r) begin
                shadow_r <= {shadow_r[WORD_BITS-2:0], 1'b0};
            end
        end
    end

    assign spi.miso = shadow_r[WORD_BITS-1];
`else
    assign spi.miso = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_conf_rx.sv
// Randomized scoreboard bench for fpga_conf_rx: frame outcomes and latency come from a
// frame-level model, pulses are checked by an independent monitor process.
module tb_fpga_conf_rx;
    import fpga_hf_pkg::*;

    logic       pck0 = 1'b0;
    logic       nrst = 1'b0;
    logic [7:0] conf_word;
    logic [2:0] major_mode;
    logic       conf_strobe;
    logic       frame_err;

    fpga_conf_rx_if spi_if ();

    fpga_conf_rx #(.SYNC_STAGES(2), .WORD_BITS(16), .CONF_BITS(8)) dut (
        .pck0        (pck0),
        .nrst        (nrst),
        .spi         (spi_if.slave),
        .conf_word   (conf_word),
        .major_mode  (major_mode),
        .conf_strobe (conf_strobe),
        .frame_err   (frame_err)
    );

    always #5 pck0 = ~pck0;

    int cyc = 0;
    always @(posedge pck0) cyc = cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] conf;
        int         due;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         total = 0;
    int         bad   = 0;
    logic [7:0] model_conf = 8'hE0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge pck0);
        #1;
    endtask

    // Monitor: every strobe/err pulse must match the oldest expected event.
    always @(negedge pck0) begin
        if (nrst && (conf_strobe || frame_err)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'({conf_strobe, frame_err}), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pulse_kind", 32'({conf_strobe, frame_err}), mon_e.is_err ? 32'd1 : 32'd2);
                chk("pulse_cycle", 32'(cyc), 32'(mon_e.due));
                if (!mon_e.is_err) chk("conf_on_strobe", 32'(conf_word), 32'(mon_e.conf));
            end
        end
    end

    // One frame: nbits bits of val MSB first, spck = pck0/8; readback checked on every bit.
    task automatic send_frame(input logic [31:0] val, input int nbits);
        logic [7:0] prev;
        logic       exp_miso;
        int         rise_c;
        exp_t       e;
        prev = model_conf;
        spi_if.ncs = 1'b0;
        wait_cycles(4);
        for (int k = 0; k < nbits; k++) begin
            spi_if.mosi = val[nbits-1-k];
            spi_if.spck = 1'b0;
            wait_cycles(4);
`ifdef FPGA_CONF_READBACK_EN
            exp_miso = (k >= 8 && k < 16) ? prev[15-k] : 1'b0;
`else
            exp_miso = 1'b0;
`endif
            chk("miso_bit", 32'(spi_if.miso), 32'(exp_miso));
            spi_if.spck = 1'b1;
            wait_cycles(4);
        end
        spi_if.spck = 1'b0;
        wait_cycles(4);
        spi_if.ncs = 1'b1;
        rise_c = cyc;
        if (nbits != 16) begin
            e.is_err = 1'b1; e.conf = model_conf; e.due = rise_c + 4;
            exp_q.push_back(e);
        end else if (val[15:12] == CMD_SET_CONFREG) begin
            e.is_err = 1'b0; e.conf = val[7:0]; e.due = rise_c + 5;
            exp_q.push_back(e);
            model_conf = val[7:0];
        end
        wait_cycles(12);
        chk("events_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        chk("conf_word", 32'(conf_word), 32'(model_conf));
        chk("major_mode", 32'(major_mode), 32'(model_conf[7:5]));
    endtask

    initial begin
        logic [31:0] val;
        int          nbits;
        logic [15:0] part;
        spi_if.ncs  = 1'b1;
        spi_if.spck = 1'b0;
        spi_if.mosi = 1'b0;
        nrst = 1'b0;
        wait_cycles(3);
        chk("rst_conf_word", 32'(conf_word), 32'hE0);
        chk("rst_major_mode", 32'(major_mode), 32'd7);
        chk("rst_pulses", 32'({conf_strobe, frame_err}), 32'd0);
        chk("rst_miso", 32'(spi_if.miso), 32'd0);
        nrst = 1'b1;
        wait_cycles(6);
        chk("post_rst_conf_word", 32'(conf_word), 32'hE0);

        send_frame(32'h1021, 16);
        send_frame(32'h2055, 16);
        send_frame(32'h00007A3C, 15);
        send_frame(32'h00012345, 17);
        send_frame(32'h0, 0);

        // Reset in the middle of frame 16'h10A0 (after 9 bits).
        part = 16'h10A0;
        spi_if.ncs = 1'b0;
        wait_cycles(4);
        for (int k = 0; k < 9; k++) begin
            spi_if.mosi = part[15-k];
            spi_if.spck = 1'b0;
            wait_cycles(4);
            spi_if.spck = 1'b1;
            wait_cycles(4);
        end
        nrst = 1'b0;
        wait_cycles(1);
        chk("midrst_conf_word", 32'(conf_word), 32'hE0);
        chk("midrst_major_mode", 32'(major_mode), 32'd7);
        spi_if.ncs  = 1'b1;
        spi_if.spck = 1'b0;
        wait_cycles(4);
        nrst = 1'b1;
        model_conf = 8'hE0;
        wait_cycles(6);
        chk("after_rst_conf_word", 32'(conf_word), 32'hE0);

        send_frame(32'h1060, 16);
        send_frame(32'h1021, 16);
        send_frame(32'h1040, 16);

        for (int n = 0; n < 20; n++) begin
            case ($urandom_range(0, 9))
                0:       nbits = 15;
                1:       nbits = 17;
                default: nbits = 16;
            endcase
            val = $urandom;
            if ($urandom_range(0, 2) != 0) val[15:12] = CMD_SET_CONFREG;
            send_frame(val, nbits);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
